// File: rtl/breath_ctrl_if.sv
// Control/status bundle between a breathing-LED ramp generator and its driver.
// The master drives run controls; the slave returns the duty ramp.
interface breath_ctrl_if;
   logic       en;
   logic       mode;
   logic       hold;
   logic [6:0] duty_cycle;
   logic       step_tick;
   logic       dir;

   modport master (output en, mode, hold, input duty_cycle, step_tick, dir);
   modport slave  (input en, mode, hold, output duty_cycle, step_tick, dir);
endinterface

// File: rtl/breath_ctrl.sv
// Breathing ramp generator: steps a percent duty up/down every STEP_CYCLES
// clocks in triangle or sawtooth shape, feeding a downstream PWM.
module breath_ctrl #(
   parameter int STEP_CYCLES = 1000,
   parameter int STEP_SIZE   = 1,
   parameter int MAX_DUTY    = 100
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   breath_ctrl_if.slave  bus
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [7:0]    STEP8    = 8'(STEP_SIZE);
   localparam logic [6:0]    STEP7    = 7'(STEP_SIZE);
   localparam logic [7:0]    MAX8     = 8'(MAX_DUTY);
   localparam logic [6:0]    MAX7     = 7'(MAX_DUTY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RISE = 2'd1;
   localparam logic [1:0] S_FALL = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] presc;
   logic [6:0]    duty, duty_nxt;
   logic [7:0]    rise_sum;
   logic          step_tick;

   // Duty/state to commit on the next tick; mode only matters while rising.
   always_comb begin
      rise_sum  = {1'b0, duty} + STEP8;
      duty_nxt  = duty;
      state_nxt = state;
      if (state == S_RISE) begin
         if (bus.mode && duty == MAX7) begin
            duty_nxt = 7'd0;
         end else if (rise_sum >= MAX8) begin
            duty_nxt = MAX7;
            if (!bus.mode) state_nxt = S_FALL;
         end else begin
            duty_nxt = rise_sum[6:0];
         end
      end else if (state == S_FALL) begin
         if ({1'b0, duty} <= STEP8) begin
            duty_nxt  = 7'd0;
            state_nxt = S_RISE;
         end else begin
            duty_nxt = duty - STEP7;
         end
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         presc     <= '0;
         duty      <= 7'd0;
         step_tick <= 1'b0;
      end else if (!bus.en) begin
         state     <= S_IDLE;
         presc     <= '0;
         duty      <= 7'd0;
         step_tick <= 1'b0;
      end else if (state == S_IDLE) begin
         state     <= S_RISE;
         presc     <= '0;
         step_tick <= 1'b0;
      end else if (bus.hold) begin
         step_tick <= 1'b0;
      end else if (presc == PRE_LAST) begin
         presc     <= '0;
         step_tick <= 1'b1;
         duty      <= duty_nxt;
         state     <= state_nxt;
      end else begin
         presc     <= presc + 1'b1;
         step_tick <= 1'b0;
      end
   end

   assign bus.duty_cycle = duty;
   assign bus.step_tick  = step_tick;
   assign bus.dir        = (state != S_FALL);

endmodule

// File: doc/breath_ctrl.md
BREATH_CTRL -- requirements
Module: breath_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1000, clock cycles between duty updates (legal range 1..2^20).
REQ-002 SHALL have parameter STEP_SIZE, default 1, duty increment or decrement per update (legal range 1..MAX_DUTY).
REQ-003 SHALL have parameter MAX_DUTY, default 100, ramp ceiling in percent (legal range 1..100).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port en, input, 1 bit: run enable; 0 forces idle.
REQ-007 SHALL have port mode, input, 1 bit: 0 = triangle ramp, 1 = sawtooth ramp.
REQ-008 SHALL have port hold, input, 1 bit: freezes the prescaler and duty while high.
REQ-009 SHALL have port duty_cycle, output, 7 bits: registered duty in percent (0..MAX_DUTY), fed directly to the downstream PWM duty_cycle input.
REQ-010 SHALL have port step_tick, output, 1 bit: one-cycle pulse, high in the cycle the new duty_cycle value first appears.
REQ-011 SHALL have port dir, output, 1 bit: 1 in IDLE/RISE, 0 in FALL.

Function
REQ-012 SHALL implement FSM states IDLE, RISE, FALL.
REQ-013 SHALL make IDLE go to RISE on the first edge with en=1.
REQ-014 SHALL make RISE or FALL go to IDLE on any edge with en=0; duty_cycle=0 and prescaler=0 on that same edge.
REQ-015 SHALL hold the prescaler at 0 in IDLE and count 0..STEP_CYCLES-1 in RISE/FALL.
REQ-016 SHALL create an internal tick when the prescaler equals STEP_CYCLES-1 with en=1 and hold=0; that same edge wraps the prescaler to 0.
REQ-017 SHALL give the first tick STEP_CYCLES cycles after entry to RISE; with STEP_CYCLES=1 a tick occurs every cycle.
REQ-018 SHALL, while hold=1, keep prescaler, duty_cycle, and state frozen; counting resumes from the frozen count when hold returns to 0; hold has no effect in IDLE.
REQ-019 SHALL, on a tick in RISE, compute duty_cycle+STEP_SIZE in 8-bit arithmetic; a result >= MAX_DUTY saturates to MAX_DUTY.
REQ-020 SHALL, in triangle mode, change state to FALL on the same edge that RISE reaches MAX_DUTY.
REQ-021 SHALL, in sawtooth mode, keep state at RISE at MAX_DUTY; the next tick sets duty_cycle=0 and state stays RISE.
REQ-022 SHALL, on a tick in FALL, set duty_cycle to 0 when duty_cycle <= STEP_SIZE and change state to RISE on that same edge; otherwise subtract STEP_SIZE.
REQ-023 SHALL sample mode only at ticks in RISE; a FALL already in progress finishes normally whatever mode is.
REQ-024 SHALL register step_tick, asserting it in exactly the cycle after each internal tick, coincident with the updated duty_cycle.
REQ-025 SHALL give en=0 priority over hold and over a tick in the same cycle.
REQ-026 SHALL keep duty_cycle within 0..MAX_DUTY at all times; no wrap-around through 127.

Reset
REQ-027 SHALL, while sys_rst_n=0, immediately force state=IDLE, prescaler=0, duty_cycle=0, step_tick=0, dir=1, without waiting for a clock edge.
REQ-028 SHALL act on reset mid-ramp the same way; after release, the first en=1 edge restarts the ramp from 0.

Verification
REQ-029 SHALL check reset with sys_rst_n=0 held for 10 cycles, en=1 -> duty_cycle=0, step_tick=0, dir=1 throughout.
REQ-030 SHALL check triangle mode with STEP_CYCLES=4, STEP_SIZE=10, en=1, mode=0 -> duty_cycle 10,20,...,100,90,...,0,10; one update every 4 cycles; step_tick pulses every 4 cycles; dir falls at 100 and rises at 0.
REQ-031 SHALL check saturation with STEP_SIZE=30, triangle mode -> duty_cycle 30,60,90,100,70,40,10,0,30.
REQ-032 SHALL check sawtooth mode with STEP_SIZE=10, mode=1 -> duty_cycle ...,90,100,0,10; dir stays 1.
REQ-033 SHALL check hold with hold=1 for 10 cycles at duty_cycle=50 -> duty_cycle stays 50 and no step_tick; next update comes exactly (4 - count frozen at hold) cycles after release.
REQ-034 SHALL check en drop and async reset mid-ramp: en=0 at duty_cycle=50 gives duty_cycle=0 on the next edge; a sys_rst_n pulse between edges during FALL clears outputs immediately; re-enable restarts from 0 in RISE.
